// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and operand-sign helpers for the RV32M mul/div unit.
// MD_IS_DIV(op) is true for the four divide/remainder encodings.
`ifndef MULDIV_PKG_SV
`define MULDIV_PKG_SV
`define MD_IS_DIV(op) (op[2])

package muldiv_pkg;
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction
endpackage
`endif

// File: rtl/muldiv_sign_fixup.sv
// Combinational sign handling: operand magnitudes and divide special cases on the
// request side, result negation and high/low/quotient/remainder selection on the result side.
module muldiv_sign_fixup
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        in_op,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  output logic              a_neg,
  output logic              b_neg,
  output logic              spec_hit,
  output logic [XLEN-1:0]   spec_res,
  input  logic [2:0]        res_op,
  input  logic              res_a_neg,
  input  logic              res_b_neg,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quo,
  input  logic [XLEN-1:0]   rem,
  output logic [XLEN-1:0]   result
);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;

  always_comb begin
    a_neg    = op_a_signed(in_op) & in_a[XLEN-1];
    b_neg    = op_b_signed(in_op) & in_b[XLEN-1];
    a_mag    = a_neg ? -in_a : in_a;
    b_mag    = b_neg ? -in_b : in_b;
    spec_hit = 1'b0;
    spec_res = '0;
    // op[1] separates REM/REMU from DIV/DIVU
    if (`MD_IS_DIV(in_op)) begin
      if (in_b == '0) begin
        spec_hit = 1'b1;
        spec_res = in_op[1] ? in_a : '1;
      end else if (op_b_signed(in_op) && (in_a == MIN_INT) && (in_b == '1)) begin
        spec_hit = 1'b1;
        spec_res = in_op[1] ? '0 : MIN_INT;
      end
    end
  end

  always_comb begin
    prod_s = (res_a_neg ^ res_b_neg) ? -prod : prod;
    quo_s  = (res_a_neg ^ res_b_neg) ? -quo : quo;
    rem_s  = res_a_neg ? -rem : rem;
    case (res_op)
      MD_MUL:                       result = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = quo_s;
      default:                      result = rem_s;
    endcase
  end
endmodule

// File: rtl/muldiv_module.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a one-cycle multiplier.
module muldiv_module
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN+1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] md_input_a,
  input  logic [XLEN-1:0] md_input_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] md_out,
  output logic            busy
);
  md_state_t         state, state_nxt;
  logic [2:0]        op_q;
  logic              a_neg_q, b_neg_q;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   b_mag_q, quo;
  logic [XLEN:0]     rem;
  logic [2*XLEN-1:0] prod;

  logic [XLEN-1:0]   a_mag, b_mag, spec_res, result, short_res;
  logic              a_neg, b_neg, spec_hit, short_hit, accept, last_step;
  logic [XLEN:0]     mul_sum, div_shift, div_diff, rem_nxt;
  logic [XLEN-1:0]   quo_nxt;
  logic [2*XLEN-1:0] prod_nxt;
  logic              unused_bits;

  muldiv_sign_fixup #(.XLEN(XLEN)) u_fixup (
    .in_op     (md_op),
    .in_a      (md_input_a),
    .in_b      (md_input_b),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .a_neg     (a_neg),
    .b_neg     (b_neg),
    .spec_hit  (spec_hit),
    .spec_res  (spec_res),
    .res_op    (op_q),
    .res_a_neg (a_neg_q),
    .res_b_neg (b_neg_q),
    .prod      (prod_nxt),
    .quo       (quo_nxt),
    .rem       (rem_nxt[XLEN-1:0]),
    .result    (result)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  logic                     unused_fast;
  assign fast_prod   = $signed({a_neg, md_input_a}) * $signed({b_neg, md_input_b});
  assign unused_fast = ^fast_prod[2*XLEN+1:2*XLEN];
  assign short_hit   = spec_hit | !`MD_IS_DIV(md_op);
  assign short_res   = spec_hit ? spec_res :
                       (md_op == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign short_hit   = spec_hit;
  assign short_res   = spec_res;
`endif

  // One shift-add or restore step; the remainder MSB stays zero since rem < divisor.
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, b_mag_q} : '0);
    prod_nxt  = {mul_sum, prod[XLEN-1:1]};
    div_shift = {rem[XLEN-1:0], quo[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    if (div_diff[XLEN]) begin
      rem_nxt = div_shift;
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt = div_diff;
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end
  end

  assign unused_bits = ^{rem[XLEN], rem_nxt[XLEN]};
  assign accept      = in_valid && in_ready && !flush;
  assign last_step   = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = short_hit ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (last_step) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      b_mag_q <= '0;
      prod    <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      md_out  <= '0;
    end else if (!flush) begin
      if (accept) begin
        op_q    <= md_op;
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
        b_mag_q <= b_mag;
        prod    <= {{XLEN{1'b0}}, a_mag};
        quo     <= a_mag;
        rem     <= '0;
        cnt     <= CNT_W'(XLEN);
        if (short_hit) md_out <= short_res;
      end else if (state == ST_BUSY) begin
        cnt <= cnt - 1'b1;
        if (`MD_IS_DIV(op_q)) begin
          quo <= quo_nxt;
          rem <= rem_nxt;
        end else begin
          prod <= prod_nxt;
        end
        if (last_step) md_out <= result;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_module.sv
// Self-checking bench for muldiv_module: directed RV32M cases, handshake/flush/reset
// scenarios and randomized ops scored against a plain-arithmetic reference.
module tb_muldiv_module;
  import muldiv_pkg::*;

  localparam int XL = 32;

  logic          clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]    md_op;
  logic [XL-1:0] md_input_a, md_input_b, md_out;
  int            n_cmp, n_bad;
  logic [XL-1:0] last_out;

  muldiv_module #(.XLEN(XL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .md_op      (md_op),
    .md_input_a (md_input_a),
    .md_input_b (md_input_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .md_out     (md_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      MD_MUL:    begin p = ua * ub; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XL + 1;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return XL + 1;
`endif
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Leaves time at #1 after the accept edge; scrambles inputs to prove they are latched.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    int   n;
    in_valid = 1'b1; md_op = op; md_input_a = a; md_input_b = b;
    n = 0;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0; md_op = 3'($urandom); md_input_a = $urandom; md_input_b = $urandom;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int hold);
    int n;
    issue(op, a, b);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat(op, a, b)));
    chk(tag, md_out, exp);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_md_out", md_out, exp);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    last_out = exp;
    release_out();
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic        ov;
    n_cmp = 0; n_bad = 0; last_out = '0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    md_op = '0; md_input_a = '0; md_input_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_md_out", md_out, 0);
    rst_n = 1'b1;

    run("mul_7_m3",   MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 10);
    run("mulh",       MD_MULH,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 0);
    run("mulhsu",     MD_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
    run("mulhu",      MD_MULHU,  32'h8000_0000,  32'hFFFF_FFFF, 32'h7FFF_FFFF, 0);
    run("div_m7_2",   MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
    run("rem_m7_2",   MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
    run("divu",       MD_DIVU,   32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 0);
    run("div_by0",    MD_DIV,    32'd123,        32'd0,         32'hFFFF_FFFF, 0);
    run("rem_by0",    MD_REM,    32'd5,          32'd0,         32'd5,         0);
    run("divu_by0",   MD_DIVU,   32'd9,          32'd0,         32'hFFFF_FFFF, 0);
    run("remu_by0",   MD_REMU,   32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF, 0);
    run("div_ovf",    MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
    run("rem_ovf",    MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         0);
    run("divu_min_m1",MD_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         0);

    // flush at BUSY cycle 5
    issue(MD_MUL, 32'd5, 32'd6);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_busy", busy, 0);
    chk("flush_md_out_kept", md_out, last_out);
    ov = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      ov |= out_valid;
    end
    chk("flush_no_valid", ov, 0);

    // flush in DONE drops out_valid but keeps md_out
    issue(MD_DIV, 32'd1, 32'd0);
    chk("done_valid", out_valid, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done_valid", out_valid, 0);
    chk("flush_done_md_out", md_out, 32'hFFFF_FFFF);

    // flush beats in_valid in IDLE
    in_valid = 1'b1; md_op = MD_MUL; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_busy", busy, 0);
    chk("flush_idle_in_ready", in_ready, 1);

    // reset mid-operation
    issue(MD_DIVU, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_md_out", md_out, 0);
    rst_n = 1'b1;
    run("after_rst", MD_REMU, 32'd1000, 32'd7, 32'd6, 0);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_val();
      rb  = pick_val();
      run("rnd", rop, ra, rb, ref_md(rop, ra, rb), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
